song_sequencer: RTL and testbench

- Auto-play controller for the buzzer datapath.
- Fetches note entries for a selected song from an external synchronous song ROM and times each note in beats. Drives the buzzer's note and octave_auto inputs, with a fixed silent gap between notes.
- Supports start/restart, pause and end-of-song detection. Sits between the mode/UI logic and the buzzer.

---
 rtl/song_pkg.sv | 35 +++
 rtl/note_timer.sv | 24 ++
 rtl/song_sequencer.sv | 139 +++++++++++++
 tb/tb_song_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer: FSM states, ROM entry
// layout, octave codes and the rest note.
package song_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  localparam int ENTRY_W  = 10;
  localparam int NOTE_MSB = 9;
  localparam int NOTE_LSB = 6;
  localparam int OCT_MSB  = 5;
  localparam int OCT_LSB  = 4;
  localparam int DUR_MSB  = 3;
  localparam int DUR_LSB  = 0;

  localparam logic [1:0] OCT_STD  = 2'b00;
  localparam logic [1:0] OCT_LOW  = 2'b01;
  localparam logic [1:0] OCT_HIGH = 2'b10;

  localparam logic [3:0] REST     = 4'd0;
  localparam logic [3:0] MAX_NOTE = 4'd7;

  // Codes above the top playable note are treated as rests.
  function automatic logic [3:0] note_or_rest(input logic [3:0] n);
    return (n > MAX_NOTE) ? REST : n;
  endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter used to time both the sounding part of a note and
// the silent gap; o_expired marks the last enabled count.
module note_timer #(
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_en,
  input  logic [CW-1:0] i_load_val,
  output logic          o_expired
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                 r_cnt <= '0;
    else if (i_load)              r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_expired = i_en && (r_cnt == CW'(1));

endmodule

// File: rtl/song_sequencer.sv
// Auto-play controller: walks a song in an external synchronous ROM, times
// each note in beats and drives the buzzer note/octave inputs.
module song_sequencer
  import song_pkg::*;
#(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int IDX_W       = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic [1:0]         song_sel,
  output logic [IDX_W+1:0]   rom_addr,
  input  logic [ENTRY_W-1:0] rom_data,
  output logic [3:0]         note,
  output logic [1:0]         octave_auto,
  output logic               playing,
  output logic               song_done
);

  localparam int CW = $clog2(15 * BEAT_CYCLES);

  state_t             r_state;
  logic [1:0]         r_song;
  logic [IDX_W-1:0]   r_idx;
  logic [ENTRY_W-1:0] r_entry;
  logic [3:0]         r_note;
  logic [1:0]         r_oct;
  logic               r_playing;
  logic               r_done;
  logic [IDX_W+1:0]   r_addr;

  logic [3:0]       w_dur;
  logic [CW-1:0]    w_play_cnt;
  logic             w_tmr_en;
  logic             w_tmr_load;
  logic [CW-1:0]    w_tmr_val;
  logic             w_expired;
  logic [IDX_W-1:0] w_idx_nxt;

  assign w_dur      = r_entry[DUR_MSB:DUR_LSB];
  assign w_play_cnt = CW'(w_dur) * CW'(BEAT_CYCLES) - CW'(GAP_CYCLES);
  assign w_idx_nxt  = r_idx + 1'b1;

  // The timer only runs in PLAY/GAP; pause freezes it there.
  assign w_tmr_en   = ~pause && (r_state == S_PLAY || r_state == S_GAP);
  assign w_tmr_load = (r_state == S_LOAD) || (r_state == S_PLAY && w_expired);
  assign w_tmr_val  = (r_state == S_LOAD) ? w_play_cnt : CW'(GAP_CYCLES);

  note_timer #(.CW(CW)) u_timer (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_tmr_load),
    .i_en       (w_tmr_en),
    .i_load_val (w_tmr_val),
    .o_expired  (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_song    <= '0;
      r_idx     <= '0;
      r_entry   <= '0;
      r_note    <= REST;
      r_oct     <= OCT_STD;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
      r_addr    <= '0;
    end else if (start) begin
      // Start and restart share one path; it also pre-empts a pending DONE.
      r_song    <= song_sel;
      r_idx     <= '0;
      r_addr    <= {song_sel, {IDX_W{1'b0}}};
      r_note    <= REST;
      r_oct     <= OCT_STD;
      r_playing <= 1'b1;
      r_done    <= 1'b0;
      r_state   <= S_FETCH;
    end else begin
      case (r_state)
        S_IDLE: r_done <= 1'b0;
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          r_entry <= rom_data;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (w_dur == 4'd0) begin
            r_note    <= REST;
            r_oct     <= OCT_STD;
            r_playing <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_note  <= note_or_rest(r_entry[NOTE_MSB:NOTE_LSB]);
            r_oct   <= r_entry[OCT_MSB:OCT_LSB];
            r_state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (w_expired) begin
            r_note  <= REST;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_expired) begin
            if (r_idx == {IDX_W{1'b1}}) begin
              r_oct     <= OCT_STD;
              r_playing <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_idx   <= w_idx_nxt;
              r_addr  <= {r_song, w_idx_nxt};
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pause silences the buzzer immediately while the stored note is kept.
  assign note        = (pause && r_state == S_PLAY) ? REST : r_note;
  assign octave_auto = r_oct;
  assign playing     = r_playing;
  assign song_done   = r_done;
  assign rom_addr    = r_addr;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: a per-song expected-output timeline built from
// the ROM contents, checked every cycle, plus hand-computed spot checks.
module tb_song_sequencer;

  localparam int BEAT = 10;
  localparam int GAP  = 2;
  localparam int IW   = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] song_sel = 2'd0;
  logic [7:0] rom_addr;
  logic [9:0] rom_data;
  logic [3:0] note;
  logic [1:0] octave_auto;
  logic       playing;
  logic       song_done;

  logic [9:0] rom [256];

  song_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .IDX_W(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pause       (pause),
    .song_sel    (song_sel),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .note        (note),
    .octave_auto (octave_auto),
    .playing     (playing),
    .song_done   (song_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [3:0] note;
    logic [1:0] oct;
    logic       ply;
    logic       dn;
    logic [7:0] addr;
    logic       pz;   // cycle stretches (note muted) while pause is high
  } exp_t;

  exp_t       q[$];
  logic [7:0] idle_addr = 8'h00;
  int n_tests = 0, n_fail = 0;
  int n_nz = 0, n_done = 0, n_n5 = 0, n_rest = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic void push(input logic [3:0] n, input logic [1:0] o, input logic p,
                               input logic d, input logic [7:0] a, input logic z, input int cnt);
    exp_t e;
    e.note = n; e.oct = o; e.ply = p; e.dn = d; e.addr = a; e.pz = z;
    for (int i = 0; i < cnt; i++) q.push_back(e);
  endfunction

  // Timeline after a start: per entry 3 fetch cycles, dur*BEAT-GAP sounding
  // cycles, GAP silent cycles; end marker or index 63 gives one DONE cycle.
  function automatic void build(input logic [1:0] s);
    logic [1:0] prev;
    logic [9:0] ent;
    logic [7:0] a;
    logic [3:0] n;
    int         dur;
    q.delete();
    prev = 2'b00;
    for (int k = 0; k < 64; k++) begin
      a = {s, 6'(k)};
      push(4'd0, prev, 1'b1, 1'b0, a, 1'b0, 3);
      ent = rom[a];
      dur = int'(ent[3:0]);
      if (dur == 0) begin
        push(4'd0, 2'b00, 1'b0, 1'b1, a, 1'b0, 1);
        return;
      end
      n = ent[9:6];
      if (n > 4'd7) n = 4'd0;
      push(n, ent[5:4], 1'b1, 1'b0, a, 1'b1, dur * BEAT - GAP);
      push(4'd0, ent[5:4], 1'b1, 1'b0, a, 1'b1, GAP);
      prev = ent[5:4];
    end
    push(4'd0, 2'b00, 1'b0, 1'b1, {s, 6'h3f}, 1'b0, 1);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic frz;
    if (q.size() > 0) e = q[0];
    else begin
      e.note = 4'd0; e.oct = 2'b00; e.ply = 1'b0; e.dn = 1'b0; e.addr = idle_addr; e.pz = 1'b0;
    end
    frz = pause && e.pz;
    chk("note", 32'(note), 32'(frz ? 4'd0 : e.note));
    chk("octave_auto", 32'(octave_auto), 32'(e.oct));
    chk("playing", 32'(playing), 32'(e.ply));
    chk("song_done", 32'(song_done), 32'(e.dn));
    chk("rom_addr", 32'(rom_addr), 32'(e.addr));
    if (note != 4'd0) n_nz++;
    if (song_done) n_done++;
    if (note == 4'd5 && octave_auto == 2'b10) n_n5++;
    if (playing && note == 4'd0 && octave_auto == 2'b01) n_rest++;
    if (q.size() > 0 && !frz) begin
      idle_addr = q[0].addr;
      void'(q.pop_front());
    end
    if (!rst_n) begin
      q.delete();
      idle_addr = 8'h00;
    end else if (start) build(song_sel);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr;
    n_nz = 0; n_done = 0; n_n5 = 0; n_rest = 0;
  endtask

  task automatic go(input logic [1:0] s);
    start = 1'b1;
    song_sel = s;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 10'd0;
    rom[8'h40] = {4'd3, 2'b00, 4'd2};
    rom[8'h80] = {4'd5, 2'b10, 4'd1};
    rom[8'h81] = {4'd9, 2'b01, 4'd1};
    rom[8'h00] = {4'd1, 2'b00, 4'd3};
    for (int k = 0; k < 64; k++) rom[8'hC0 + k] = {4'(k % 8), 2'(k % 4), 4'd1};

    tick(2);
    chk("rst_note", 32'(note), 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_done", 32'(song_done), 0);
    rst_n = 1'b1;
    tick(2);

    // basic play
    clr();
    go(2'd1);
    chk("t1_addr_after_start", 32'(rom_addr), 32'h40);
    tick(3);
    chk("t1_note_latency", 32'(note), 3);
    tick(40);
    chk("t1_note_cycles", n_nz, 18);
    chk("t1_done_count", n_done, 1);
    chk("t1_final_addr", 32'(rom_addr), 32'h41);
    chk("t1_playing_low", 32'(playing), 0);

    // octave and rest
    clr();
    go(2'd2);
    tick(40);
    chk("t2_high_oct_cycles", n_n5, 8);
    chk("t2_low_oct_rest_cycles", n_rest, 13);
    chk("t2_done_count", n_done, 1);

    // pause mid-note
    clr();
    go(2'd0);
    tick(3);
    chk("t3_note_on", 32'(note), 1);
    tick(10);
    pause = 1'b1;
    #1;
    chk("t3_paused_note", 32'(note), 0);
    tick(7);
    pause = 1'b0;
    tick(40);
    chk("t3_note_cycles", n_nz, 28);
    chk("t3_done_count", n_done, 1);

    // restart during PLAY
    clr();
    go(2'd0);
    tick(8);
    go(2'd2);
    chk("t4_note_after_restart", 32'(note), 0);
    chk("t4_addr_after_restart", 32'(rom_addr), 32'h80);
    tick(50);
    chk("t4_done_count", n_done, 1);

    // 64 entries, no end marker
    clr();
    go(2'd3);
    tick(845);
    chk("t5_done_count", n_done, 1);
    chk("t5_final_addr", 32'(rom_addr), 32'hFF);
    chk("t5_playing_low", 32'(playing), 0);

    // start on the edge that would enter DONE
    clr();
    go(2'd1);
    tick(25);
    go(2'd1);
    chk("t7_addr_restart", 32'(rom_addr), 32'h40);
    tick(40);
    chk("t7_done_count", n_done, 1);

    // reset mid-note
    clr();
    go(2'd0);
    tick(6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_note", 32'(note), 0);
    chk("t6_playing", 32'(playing), 0);
    chk("t6_addr", 32'(rom_addr), 0);
    tick(20);
    chk("t6_still_idle", 32'(playing), 0);
    chk("t6_done_count", n_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
